cr_tlvp_merge: RTL

- Downstream neighbour of the TLV parser/splitter stage.
- Drains the pass-through (pt_ib) and user (usr_ib) show-ahead FIFOs and re-interleaves whole TLVs back into one ordered stream.
- Ordering uses a per-TLV sequence tag that the splitter stamps on each TLV's first word.
- Output is a single registered valid/ready stage feeding the module's outbound path.

---
 rtl/cr_tlvp_merge_if.sv | 46 ++++
 rtl/cr_tlvp_merge.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cr_tlvp_merge_if.sv
// Bundle between cr_tlvp_merge and its two show-ahead inbound FIFOs plus the outbound stream.
// master = the merge block, slave = FIFOs/downstream side.
interface cr_tlvp_merge_if #(
  parameter int DATA_W = 64,
  parameter int SEQ_W  = 4
);
  logic              pt_ib_empty;
  logic [DATA_W-1:0] pt_ib_data;
  logic              pt_ib_sot;
  logic              pt_ib_eot;
  logic [SEQ_W-1:0]  pt_ib_seq;
  logic              pt_ib_rd;

  logic              usr_ib_empty;
  logic [DATA_W-1:0] usr_ib_data;
  logic              usr_ib_sot;
  logic              usr_ib_eot;
  logic [SEQ_W-1:0]  usr_ib_seq;
  logic              usr_ib_rd;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sot;
  logic              out_eot;
  logic              out_src;
  logic              merge_error;

  modport master (
    input  pt_ib_empty, pt_ib_data, pt_ib_sot, pt_ib_eot, pt_ib_seq,
    output pt_ib_rd,
    input  usr_ib_empty, usr_ib_data, usr_ib_sot, usr_ib_eot, usr_ib_seq,
    output usr_ib_rd,
    output out_valid, out_data, out_sot, out_eot, out_src, merge_error,
    input  out_ready
  );

  modport slave (
    output pt_ib_empty, pt_ib_data, pt_ib_sot, pt_ib_eot, pt_ib_seq,
    input  pt_ib_rd,
    output usr_ib_empty, usr_ib_data, usr_ib_sot, usr_ib_eot, usr_ib_seq,
    input  usr_ib_rd,
    input  out_valid, out_data, out_sot, out_eot, out_src, merge_error,
    output out_ready
  );
endinterface

// File: rtl/cr_tlvp_merge.sv
// Re-interleaves whole TLVs from the pt and usr FIFOs in sequence-tag order into one registered stream.
// Optional CR_TLVP_MERGE_STATS_EN adds saturating TLV/error counters.
module cr_tlvp_merge #(
  parameter int DATA_W = 64,
  parameter int SEQ_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cr_tlvp_merge_if.master       mrg
`ifdef CR_TLVP_MERGE_STATS_EN
  ,
  output logic [31:0]           pt_tlv_cnt,
  output logic [31:0]           usr_tlv_cnt,
  output logic [31:0]           err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PT_XFER  = 2'd1,
    USR_XFER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SEQ_W-1:0]  exp_seq_q, exp_seq_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sot_q, out_sot_d;
  logic              out_eot_q, out_eot_d;
  logic              out_src_q, out_src_d;
  logic              err_q, err_d;

  logic              load;
  logic              pt_cand, usr_cand;
  logic              pt_pop, usr_pop, emit;
  logic [DATA_W-1:0] sel_data;
  logic              sel_sot, sel_eot;

  always_comb begin
    load      = !out_valid_q || mrg.out_ready;
    pt_cand   = !mrg.pt_ib_empty && mrg.pt_ib_sot && (mrg.pt_ib_seq == exp_seq_q);
    usr_cand  = !mrg.usr_ib_empty && mrg.usr_ib_sot && (mrg.usr_ib_seq == exp_seq_q);
    state_d   = state_q;
    exp_seq_d = exp_seq_q;
    pt_pop    = 1'b0;
    usr_pop   = 1'b0;
    emit      = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Candidates first; a stalled output simply defers the pop.
        if (pt_cand || usr_cand) begin
          if (load && pt_cand) begin
            pt_pop  = 1'b1;
            emit    = 1'b1;
            err_d   = usr_cand;
            state_d = PT_XFER;
          end else if (load) begin
            usr_pop = 1'b1;
            emit    = 1'b1;
            state_d = USR_XFER;
          end
        end else if (!mrg.pt_ib_empty && !mrg.usr_ib_empty &&
                     mrg.pt_ib_sot && mrg.usr_ib_sot) begin
          err_d     = 1'b1;
          exp_seq_d = mrg.pt_ib_seq;
        end else if (load && !mrg.pt_ib_empty && !mrg.pt_ib_sot) begin
          pt_pop = 1'b1;
          err_d  = 1'b1;
        end else if (load && !mrg.usr_ib_empty && !mrg.usr_ib_sot) begin
          usr_pop = 1'b1;
          err_d   = 1'b1;
        end
      end
      PT_XFER: begin
        if (load && !mrg.pt_ib_empty) begin
          pt_pop = 1'b1;
          emit   = 1'b1;
          err_d  = mrg.pt_ib_sot;
        end
      end
      USR_XFER: begin
        if (load && !mrg.usr_ib_empty) begin
          usr_pop = 1'b1;
          emit    = 1'b1;
          err_d   = mrg.usr_ib_sot;
        end
      end
      default: state_d = IDLE;
    endcase

    sel_data = usr_pop ? mrg.usr_ib_data : mrg.pt_ib_data;
    sel_sot  = usr_pop ? mrg.usr_ib_sot  : mrg.pt_ib_sot;
    sel_eot  = usr_pop ? mrg.usr_ib_eot  : mrg.pt_ib_eot;

    if (emit && sel_eot) begin
      exp_seq_d = exp_seq_q + 1'b1;
      state_d   = IDLE;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sot_d   = out_sot_q;
    out_eot_d   = out_eot_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = emit;
      if (emit) begin
        out_data_d = sel_data;
        out_sot_d  = sel_sot;
        out_eot_d  = sel_eot;
        out_src_d  = usr_pop;
      end
    end
  end

  // Output/state register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_seq_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sot_q   <= 1'b0;
      out_eot_q   <= 1'b0;
      out_src_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_seq_q   <= exp_seq_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sot_q   <= out_sot_d;
      out_eot_q   <= out_eot_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
    end
  end

  assign mrg.pt_ib_rd    = pt_pop && !rst;
  assign mrg.usr_ib_rd   = usr_pop && !rst;
  assign mrg.out_valid   = out_valid_q;
  assign mrg.out_data    = out_data_q;
  assign mrg.out_sot     = out_sot_q;
  assign mrg.out_eot     = out_eot_q;
  assign mrg.out_src     = out_src_q;
  assign mrg.merge_error = err_q;

`ifdef CR_TLVP_MERGE_STATS_EN
  logic        pt_done, usr_done;
  logic [31:0] pt_tlv_cnt_q, usr_tlv_cnt_q, err_cnt_q;

  assign pt_done  = emit && pt_pop && sel_eot;
  assign usr_done = emit && usr_pop && sel_eot;

  always_ff @(posedge clk) begin
    if (rst) begin
      pt_tlv_cnt_q  <= '0;
      usr_tlv_cnt_q <= '0;
      err_cnt_q     <= '0;
    end else begin
      if (pt_done && (pt_tlv_cnt_q != 32'hFFFF_FFFF))
        pt_tlv_cnt_q <= pt_tlv_cnt_q + 32'd1;
      if (usr_done && (usr_tlv_cnt_q != 32'hFFFF_FFFF))
        usr_tlv_cnt_q <= usr_tlv_cnt_q + 32'd1;
      if (err_d && (err_cnt_q != 32'hFFFF_FFFF))
        err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign pt_tlv_cnt  = pt_tlv_cnt_q;
  assign usr_tlv_cnt = usr_tlv_cnt_q;
  assign err_cnt     = err_cnt_q;
`endif

endmodule
